// File: rtl/sram_if_feeder.sv
// Sequencer that streams word_count SRAM words from base_addr into a PE input buffer,
// hiding the 1-cycle SRAM read latency behind a 2-entry skid FIFO. Optional: FEEDER_STRIDE_EN.
module sram_if_feeder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
`ifdef FEEDER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] addr_stride,
`endif
  output logic [ADDR_WIDTH-1:0] sram_read_addr,
  input  logic [DATA_WIDTH-1:0] sram_read_data,
  input  logic                  buf_full,
  output logic                  buf_wen,
  output logic [DATA_WIDTH-1:0] buf_din,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH-1:0] stride;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic                  in_flight_q;
  logic [1:0]            fifo_cnt_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  logic       accept_start;
  logic       push;
  logic       pop;
  logic       flush;
  logic       issue;
  logic       drained;
  logic [1:0] occupancy;

  assign accept_start = (state_q == IDLE) && start && (word_count != '0);
  assign flush        = (state_q == RUN) && abort;

  // The head register doubles as buf_din, so it keeps its last value whenever the FIFO is empty.
  assign pop     = (fifo_cnt_q != 2'd0) && !buf_full;
  assign push    = in_flight_q;
  assign buf_wen = pop;
  assign buf_din = head_q;

  // Slots already spoken for after this cycle's pop; a new read needs one free slot to land in.
  assign occupancy = fifo_cnt_q + {1'b0, in_flight_q} - {1'b0, pop};
  assign issue     = (state_q == RUN) && !abort && (issued_q < count_q) && (occupancy < 2'd2);

  // Finish on the edge that accepts the final word, so done lands in the very next cycle.
  assign drained = (issued_q == count_q) && !in_flight_q && (fifo_cnt_q == {1'b0, pop});

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef FEEDER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_q <= '0;
    end else if (accept_start) begin
      stride_q <= addr_stride;
    end
  end

  assign stride = stride_q;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (word_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (drained) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-issue side: address accumulator, issue counter and in-flight flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_read_addr <= '0;
      next_addr_q    <= '0;
      count_q        <= '0;
      issued_q       <= '0;
      in_flight_q    <= 1'b0;
    end else begin
      in_flight_q <= issue;
      if (accept_start) begin
        next_addr_q <= base_addr;
        count_q     <= word_count;
        issued_q    <= '0;
      end else if (issue) begin
        sram_read_addr <= next_addr_q;
        next_addr_q    <= next_addr_q + stride;
        issued_q       <= issued_q + CNT_WIDTH'(1);
      end
    end
  end

  // Two-entry shift FIFO: head_q is always the oldest word, tail_q the younger one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_cnt_q <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else if (flush) begin
      fifo_cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) begin
            head_q <= sram_read_data;
          end else begin
            tail_q <= sram_read_data;
          end
          fifo_cnt_q <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          if (fifo_cnt_q == 2'd2) begin
            head_q <= tail_q;
          end
          fifo_cnt_q <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            head_q <= sram_read_data;
          end else begin
            head_q <= tail_q;
            tail_q <= sram_read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_if_feeder.sv
// Self-checking bench for sram_if_feeder: random SRAM contents and backpressure, checked against
// an address-list model (word n = mem[base + n*stride]). Define FEEDER_STRIDE_EN to test stride.
module tb_sram_if_feeder;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          buf_full;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
`ifdef FEEDER_STRIDE_EN
  logic [AW-1:0] addr_stride;
`endif
  logic [AW-1:0] sram_read_addr;
  logic [DW-1:0] sram_read_data;
  logic          buf_wen;
  logic [DW-1:0] buf_din;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] got [$];
  int            wen_cyc [$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            done_total = 0;
  int            done_cyc = -1;
  int            s_cyc = 0;
  logic [AW-1:0] cur_stride = 8'd1;

  sram_if_feeder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .word_count    (word_count),
`ifdef FEEDER_STRIDE_EN
    .addr_stride   (addr_stride),
`endif
    .sram_read_addr(sram_read_addr),
    .sram_read_data(sram_read_data),
    .buf_full      (buf_full),
    .buf_wen       (buf_wen),
    .buf_din       (buf_din),
    .busy          (busy),
    .done          (done)
  );

  // The address port is registered inside the DUT, so data is valid in the cycle after issue.
  assign sram_read_data = mem[sram_read_addr];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // One clock: apply buf_full for the new cycle, then sample the DUT mid-cycle.
  task automatic tick(input logic full);
    @(posedge clk);
    #1;
    buf_full = full;
    #2;
    cyc++;
    if (rst) begin
      if (buf_wen) begin
        got.push_back(buf_din);
        wen_cyc.push_back(cyc);
        if (buf_full) begin
          miscompares++;
          $display("FAIL wen_while_full: buf_wen=1 with buf_full=1 at cycle %0d, required buf_wen=0", cyc);
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
      if (dut.in_flight_q && dut.fifo_cnt_q == 2'd2 && !buf_wen) begin
        miscompares++;
        $display("FAIL fifo_overflow: push into full FIFO at cycle %0d", cyc);
      end
    end
  endtask

  task automatic do_start(input string name, input logic [AW-1:0] b, input logic [CW-1:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
`ifdef FEEDER_STRIDE_EN
    addr_stride = cur_stride;
`endif
    s_cyc = cyc;
    tick(1'b0);
    start = 1'b0;
    vectors++;
    if (busy !== (c != '0)) begin
      miscompares++;
      $display("FAIL %s_busy_after_start: got %b, expected %b", name, busy, (c != '0));
    end
    vectors++;
    if (done !== (c == '0)) begin
      miscompares++;
      $display("FAIL %s_done_after_start: got %b, expected %b", name, done, (c == '0));
    end
  endtask

  task automatic run_xfer(input string name, input logic [AW-1:0] b, input logic [CW-1:0] c,
                          input bit rnd, input int fs, input int fl, output logic [AW-1:0] peak);
    int            g0;
    int            d0;
    int            n;
    int            off;
    int            nchk;
    int            exp_done;
    logic          full;
    logic [DW-1:0] exp;
    g0   = got.size();
    d0   = done_total;
    peak = '0;
    n    = 0;
    do_start(name, b, c);
    while (done_total == d0 && n < 300) begin
      off = cyc + 1 - s_cyc;
      if (rnd) full = ($urandom_range(0, 2) == 0);
      else     full = (off >= fs) && (off < fs + fl);
      if (rnd && n == 1) begin
        start      = 1'b1;
        base_addr  = AW'($urandom);
        word_count = CW'($urandom_range(1, 20));
      end
      tick(full);
      start = 1'b0;
      if (full && sram_read_addr > peak) peak = sram_read_addr;
      n++;
    end
    vectors++;
    if (done_total == d0) begin
      miscompares++;
      $display("FAIL %s_done_timeout: no done pulse within %0d cycles", name, n);
    end
    tick(1'b0);
    tick(1'b0);
    vectors++;
    if (done_total - d0 != 1) begin
      miscompares++;
      $display("FAIL %s_done_pulses: got %0d, expected 1", name, done_total - d0);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy_after_done: got %b, expected 0", name, busy);
    end
    vectors++;
    if (got.size() - g0 != int'(c)) begin
      miscompares++;
      $display("FAIL %s_word_count: got %0d writes, expected %0d", name, got.size() - g0, c);
    end
    nchk = (got.size() - g0 < int'(c)) ? got.size() - g0 : int'(c);
    for (int i = 0; i < nchk; i++) begin
      exp = mem[AW'(int'(b) + i * int'(cur_stride))];
      vectors++;
      if (got[g0 + i] !== exp) begin
        miscompares++;
        $display("FAIL %s_data[%0d]: got %h, expected %h", name, i, got[g0 + i], exp);
      end
    end
    if (c == '0) exp_done = s_cyc + 1;
    else if (got.size() > g0) exp_done = wen_cyc[wen_cyc.size() - 1] + 1;
    else exp_done = -1;
    vectors++;
    if (done_cyc != exp_done) begin
      miscompares++;
      $display("FAIL %s_done_cycle: got %0d, expected %0d", name, done_cyc, exp_done);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    buf_full   = 1'b0;
    base_addr  = '0;
    word_count = '0;
`ifdef FEEDER_STRIDE_EN
    addr_stride = '0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    #1 rst = 1'b0;
    tick(1'b0);
    tick(1'b0);
    vectors++;
    if (sram_read_addr !== '0 || buf_wen !== 1'b0 || buf_din !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: addr=%h wen=%b din=%h busy=%b done=%b, expected all 0",
               sram_read_addr, buf_wen, buf_din, busy, done);
    end
    rst = 1'b1;
    tick(1'b0);
  endtask

  task automatic test_basic();
    int            g0;
    logic [AW-1:0] peak;
    mem[8'h10] = 16'hA11A;
    mem[8'h11] = 16'hB22B;
    mem[8'h12] = 16'hC33C;
    mem[8'h13] = 16'hD44D;
    g0 = got.size();
    run_xfer("basic", 8'h10, 8'd4, 1'b0, 0, 0, peak);
    vectors++;
    if (wen_cyc.size() < g0 + 4) begin
      miscompares++;
      $display("FAIL basic_timing: only %0d writes seen, expected 4", wen_cyc.size() - g0);
    end else if (wen_cyc[g0] != s_cyc + 3 || wen_cyc[g0 + 3] != s_cyc + 6) begin
      miscompares++;
      $display("FAIL basic_timing: writes at +%0d..+%0d, expected +3..+6",
               wen_cyc[g0] - s_cyc, wen_cyc[g0 + 3] - s_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] peak;
    run_xfer("backpressure", 8'h10, 8'd4, 1'b0, 4, 5, peak);
    vectors++;
    if (peak > 8'h12) begin
      miscompares++;
      $display("FAIL backpressure_addr_stall: got %h, expected at most 12", peak);
    end
  endtask

  task automatic test_zero_count();
    logic [AW-1:0] a0;
    logic [AW-1:0] peak;
    a0 = sram_read_addr;
    run_xfer("zero", 8'h33, 8'd0, 1'b0, 0, 0, peak);
    vectors++;
    if (sram_read_addr !== a0) begin
      miscompares++;
      $display("FAIL zero_addr_unchanged: got %h, expected %h", sram_read_addr, a0);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] peak;
    mem[8'hFE] = 16'h0FE0;
    mem[8'hFF] = 16'h0FF0;
    mem[8'h00] = 16'h1000;
    mem[8'h01] = 16'h1001;
    run_xfer("wrap", 8'hFE, 8'd4, 1'b0, 0, 0, peak);
  endtask

  task automatic test_abort();
    int            g0;
    int            d0;
    int            late;
    int            abort_cyc;
    logic [AW-1:0] peak;
    g0 = got.size();
    d0 = done_total;
    do_start("abort", 8'h20, 8'd8);
    tick(1'b0);
    tick(1'b0);
    abort     = 1'b1;
    abort_cyc = cyc;
    tick(1'b0);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b, expected 0", busy);
    end
    for (int i = 0; i < 10; i++) tick(1'b0);
    late = 0;
    for (int i = g0; i < wen_cyc.size(); i++) if (wen_cyc[i] > abort_cyc) late++;
    vectors++;
    if (late != 0) begin
      miscompares++;
      $display("FAIL abort_no_writes: got %0d writes after abort, expected 0", late);
    end
    vectors++;
    if (done_total != d0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", done_total - d0);
    end
    run_xfer("after_abort", 8'h50, 8'd5, 1'b0, 0, 0, peak);
  endtask

  task automatic test_reset_mid_run();
    logic [AW-1:0] peak;
    do_start("rst_mid", 8'h40, 8'd8);
    for (int i = 0; i < 4; i++) tick(1'b0);
    rst = 1'b0;
    #1;
    vectors++;
    if (sram_read_addr !== '0 || buf_wen !== 1'b0 || buf_din !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: addr=%h wen=%b din=%h busy=%b done=%b, expected all 0",
               sram_read_addr, buf_wen, buf_din, busy, done);
    end
    tick(1'b0);
    tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
    run_xfer("after_rst", 8'h60, 8'd6, 1'b0, 0, 0, peak);
  endtask

`ifdef FEEDER_STRIDE_EN
  task automatic test_stride();
    logic [AW-1:0] peak;
    cur_stride = 8'd3;
    mem[8'h00] = 16'h5000;
    mem[8'h03] = 16'h5003;
    mem[8'h06] = 16'h5006;
    run_xfer("stride3", 8'h00, 8'd3, 1'b0, 0, 0, peak);
    cur_stride = 8'd0;
    run_xfer("stride0", 8'h77, 8'd3, 1'b0, 0, 0, peak);
    cur_stride = 8'd1;
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] peak;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
`ifdef FEEDER_STRIDE_EN
      cur_stride = AW'($urandom_range(0, 7));
`endif
      run_xfer("random", AW'($urandom), CW'($urandom_range(1, 12)), 1'b1, 0, 0, peak);
    end
    cur_stride = 8'd1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_abort();
    test_reset_mid_run();
`ifdef FEEDER_STRIDE_EN
    test_stride();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_if_feeder.md
Name: sram_if_feeder

Overview:
- Sequencer between the on-chip SRAM and a PE's IF/filter input buffer.
- On `start`, reads `word_count` consecutive SRAM words from `base_addr` and pushes each one into the PE input buffer through its `wen`/`full` write port.
- Hides the 1-cycle synchronous SRAM read latency with a 2-entry internal skid FIFO. Sustains 1 word/cycle while the PE buffer is not full.

Parameters:
- ADDR_WIDTH, 8, SRAM address width
- DATA_WIDTH, 16, SRAM word width and PE buffer din width
- CNT_WIDTH, 8, width of the word counter / `word_count`

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  1-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel of a running transfer
- base_addr  in  ADDR_WIDTH  first SRAM address, latched on start
- word_count  in  CNT_WIDTH  number of words to move, latched on start
- sram_read_addr  out  ADDR_WIDTH  registered SRAM read address
- sram_read_data  in  DATA_WIDTH  SRAM data, valid 1 cycle after address
- buf_full  in  1  PE input buffer full
- buf_wen  out  1  PE buffer write enable
- buf_din  out  DATA_WIDTH  PE buffer write data
- busy  out  1  high from accepted start until done
- done  out  1  1-cycle pulse when last word is accepted

Behaviour:
- Reset (rst=0, async): state IDLE; FIFO empty; in-flight flag 0; sram_read_addr=0, buf_wen=0, buf_din=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
  - IDLE, start=1, word_count!=0: latch base/count → RUN; busy=1 next cycle.
  - IDLE, start=1, word_count=0: → DONE directly; no reads, no writes.
  - RUN → DONE once issued==count, FIFO empty and nothing in flight.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Read issue (RUN):
  - Issue when issued<count and (FIFO occupancy + in-flight − pop this cycle) < 2.
  - On issue: sram_read_addr <= base+issued; in-flight <= 1; issued++.
  - Data returning on sram_read_data the next cycle is pushed into the FIFO.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error flag.
- Write side:
  - buf_wen = FIFO non-empty & ~buf_full. This is combinational from registered FIFO state and the buf_full input.
  - buf_din = FIFO head, registered; it holds its value while buf_wen=0.
  - A word counts as accepted on any cycle with buf_wen=1.
- Simultaneous FIFO push and pop is allowed; occupancy is unchanged.
- FIFO never overflows: the issue rule guarantees a slot for every in-flight word. A violation is an assertion failure in the bench.
- buf_full held high stalls the block indefinitely with no data loss. The address stops advancing once the FIFO plus in-flight count reaches 2.
- Latency, start sampled at edge E0:
  - sram_read_addr=base after E1.
  - Data captured into FIFO at E2.
  - buf_wen=1 in the cycle after E2 if buf_full=0.
  - Steady state: 1 word/cycle.
  - done pulses in the cycle after the last accepted write.
- abort=1 in RUN: FIFO flushed, in-flight data discarded, → IDLE next edge, busy=0, no done pulse. abort is ignored in IDLE and DONE.
- start while busy is ignored.
- Reset mid-transfer returns immediately to reset values; partial writes already done are not undone.

Optional Feature:
- Macro: FEEDER_STRIDE_EN.
- Defined:
  - Adds input `addr_stride`, width ADDR_WIDTH, latched on start.
  - Read address n = base + n*stride, computed by accumulation, modulo 2^ADDR_WIDTH.
  - stride=0 re-reads base count times.
- Undefined: port absent; stride fixed at 1.

Test Plan:
- Basic: SRAM[0x10..0x13]=A,B,C,D; start with base=0x10, count=4, buf_full=0.
  - buf_wen high 4 consecutive cycles with din A,B,C,D, first in 3rd cycle after start.
  - done pulses once; busy low afterwards.
- Backpressure: same setup, buf_full=1 for 5 cycles starting after the first write.
  - No write while full.
  - sram_read_addr stalls at 0x12 at most.
  - Order A,B,C,D preserved; no duplicates or losses.
- Zero count: start with count=0.
  - No buf_wen.
  - done pulses in the cycle after start; sram_read_addr unchanged.
- Wrap: base=0xFE, count=4.
  - Reads 0xFE, 0xFF, 0x00, 0x01, written in that order.
- Abort/reset: abort in 3rd RUN cycle.
  - No further buf_wen, no done; busy=0 next cycle.
  - A new start works normally.
  - Repeat with rst=0 mid-run: outputs zero asynchronously.
- (FEEDER_STRIDE_EN) base=0, stride=3, count=3.
  - Reads 0, 3, 6 → written in order; done pulses once.
